// File: rtl/rv_iopmp_err_capture.sv
// rv_iopmp_err_capture
// Error-record stage behind the IOPMP decision logic. The first failing
// transaction is latched into a locked record. That record backs the
// ERR_REQINFO/ERR_REQADDR/ERR_REQID view and raises a level interrupt.
// Errors that arrive while the record is locked are dropped and never
// overwrite the record.
// Optional feature macro: RV_IOPMP_ERR_DROP_CNT_EN
//   defined   -> saturating counter of dropped error events on drop_cnt_o
//   undefined -> drop_cnt_o is tied to zero and no counter flops exist
module rv_iopmp_err_capture #(
   parameter int ADDR_WIDTH = 64,
   parameter int SID_WIDTH  = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  txn_valid_i,
   input  logic                  err_transaction_i,
   input  logic [2:0]            err_type_i,
   input  logic [15:0]           err_entry_index_i,
   input  logic [2:0]            txn_access_i,
   input  logic [ADDR_WIDTH-1:0] txn_addr_i,
   input  logic [SID_WIDTH-1:0]  txn_sid_i,
   input  logic                  intr_en_i,
   input  logic                  clear_i,
   output logic                  err_v_o,
   output logic [2:0]            err_ttype_o,
   output logic [2:0]            err_etype_o,
   output logic [15:0]           err_eid_o,
   output logic [ADDR_WIDTH-1:0] err_addr_o,
   output logic [SID_WIDTH-1:0]  err_sid_o,
   output logic                  irq_o,
   output logic                  err_event_o,
   output logic [CNT_WIDTH-1:0]  drop_cnt_o
);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t state_r;
   state_t state_nx_s;
   logic   evt_s;
   logic   capture_s;
   logic   event_r;

   // A verdict only counts as an error event when it is valid this cycle.
   assign evt_s = txn_valid_i & err_transaction_i;

   // State register for the record lock.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state and capture decision. A clear and an error in the same
   // cycle replace the record, so the lock stays held.
   always_comb begin
      state_nx_s = state_r;
      capture_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (evt_s) begin
               capture_s  = 1'b1;
               state_nx_s = LOCKED;
            end else begin
               state_nx_s = IDLE;
            end
         end
         LOCKED: begin
            if (clear_i) begin
               capture_s  = evt_s;
               state_nx_s = evt_s ? LOCKED : IDLE;
            end else begin
               state_nx_s = LOCKED;
            end
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // Record fields. They keep stale data after a clear because software
   // qualifies them with err_v_o.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_ttype_o <= 3'd0;
         err_etype_o <= 3'd0;
         err_eid_o   <= 16'd0;
         err_addr_o  <= {ADDR_WIDTH{1'b0}};
         err_sid_o   <= {SID_WIDTH{1'b0}};
      end else if (capture_s) begin
         err_ttype_o <= txn_access_i;
         err_etype_o <= err_type_i;
         err_eid_o   <= err_entry_index_i;
         err_addr_o  <= txn_addr_i;
         err_sid_o   <= txn_sid_i;
      end
   end

   // One-cycle pulse per error verdict, whether it is captured or dropped.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         event_r <= 1'b0;
      end else begin
         event_r <= evt_s;
      end
   end

   assign err_event_o = event_r;
   assign err_v_o     = (state_r == LOCKED);
   assign irq_o       = err_v_o & intr_en_i;

`ifdef RV_IOPMP_ERR_DROP_CNT_EN
   logic                 drop_s;
   logic                 clear_acc_s;
   logic [CNT_WIDTH-1:0] drop_cnt_r;

   assign drop_s      = evt_s & (state_r == LOCKED) & ~clear_i;
   assign clear_acc_s = clear_i & (state_r == LOCKED);

   // Saturating dropped-error counter. An accepted clear takes priority
   // over an increment.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         drop_cnt_r <= {CNT_WIDTH{1'b0}};
      end else if (clear_acc_s) begin
         drop_cnt_r <= {CNT_WIDTH{1'b0}};
      end else if (drop_s && (drop_cnt_r != {CNT_WIDTH{1'b1}})) begin
         drop_cnt_r <= drop_cnt_r + CNT_WIDTH'(1);
      end
   end

   assign drop_cnt_o = drop_cnt_r;
`else
   assign drop_cnt_o = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_rv_iopmp_err_capture.sv
// Self-checking bench for rv_iopmp_err_capture: a directed vector table,
// hand-written corner sequences, and randomized traffic checked against a
// behavioural model of the error-record rules.
module tb_rv_iopmp_err_capture;

   localparam int AW = 64;
   localparam int SW = 8;
   localparam int CW = 2;
`ifdef RV_IOPMP_ERR_DROP_CNT_EN
   localparam bit FEAT = 1'b1;
`else
   localparam bit FEAT = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          valid = 1'b0, err = 1'b0, ie = 1'b0, clr = 1'b0;
   logic [2:0]    etype = 3'd0, acc = 3'd0;
   logic [15:0]   eid = 16'd0;
   logic [AW-1:0] addr = 64'd0;
   logic [SW-1:0] sid = 8'd0;
   logic          v_o, irq_o, ev_o;
   logic [2:0]    ttype_o, etype_o;
   logic [15:0]   eid_o;
   logic [AW-1:0] addr_o;
   logic [SW-1:0] sid_o;
   logic [CW-1:0] drop_o;

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural model state
   bit          m_locked;
   logic [2:0]  m_ttype, m_etype;
   logic [15:0] m_eid;
   logic [63:0] m_addr;
   logic [7:0]  m_sid;
   bit          m_ev;
   int          m_drop;

   rv_iopmp_err_capture #(.ADDR_WIDTH(AW), .SID_WIDTH(SW), .CNT_WIDTH(CW)) dut (
      .clk_i(clk), .rst_i(rst), .txn_valid_i(valid), .err_transaction_i(err),
      .err_type_i(etype), .err_entry_index_i(eid), .txn_access_i(acc),
      .txn_addr_i(addr), .txn_sid_i(sid), .intr_en_i(ie), .clear_i(clr),
      .err_v_o(v_o), .err_ttype_o(ttype_o), .err_etype_o(etype_o),
      .err_eid_o(eid_o), .err_addr_o(addr_o), .err_sid_o(sid_o),
      .irq_o(irq_o), .err_event_o(ev_o), .drop_cnt_o(drop_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valid, err;
      logic [2:0]  etype, acc;
      logic [15:0] eid;
      logic [63:0] addr;
      logic [7:0]  sid;
      logic        ie, clr;
      logic        x_v, x_irq, x_ev;
      logic [2:0]  x_etype;
      logic [15:0] x_eid;
      logic [63:0] x_addr;
      int          x_drop_feat;
   } vec_t;

   vec_t vt[9];

   function automatic vec_t mk(logic vl, logic er, logic [2:0] et, logic [2:0] ac,
                               logic [15:0] ei, logic [63:0] ad, logic [7:0] si,
                               logic ien, logic cl, logic xv, logic xirq, logic xev,
                               logic [2:0] xet, logic [15:0] xei, logic [63:0] xad,
                               int xdr);
      vec_t r;
      r.valid = vl; r.err = er; r.etype = et; r.acc = ac; r.eid = ei; r.addr = ad;
      r.sid = si; r.ie = ien; r.clr = cl; r.x_v = xv; r.x_irq = xirq; r.x_ev = xev;
      r.x_etype = xet; r.x_eid = xei; r.x_addr = xad; r.x_drop_feat = xdr;
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_locked = 1'b0; m_ttype = 3'd0; m_etype = 3'd0; m_eid = 16'd0;
      m_addr = 64'd0; m_sid = 8'd0; m_ev = 1'b0; m_drop = 0;
   endtask

   // Applies the rules for one clock edge to the currently driven inputs.
   task automatic model_step();
      bit e;
      e = valid && err;
      m_ev = e;
      if (e && (!m_locked || clr)) begin
         m_ttype = acc; m_etype = etype; m_eid = eid; m_addr = addr; m_sid = sid;
         if (m_locked) m_drop = 0;
         m_locked = 1'b1;
      end else if (e) begin
         if (m_drop < (1 << CW) - 1) m_drop = m_drop + 1;
      end else if (m_locked && clr) begin
         m_locked = 1'b0;
         m_drop = 0;
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".v"},     64'(v_o),     64'(m_locked));
      check({tag, ".irq"},   64'(irq_o),   64'(m_locked && ie));
      check({tag, ".event"}, 64'(ev_o),    64'(m_ev));
      check({tag, ".ttype"}, 64'(ttype_o), 64'(m_ttype));
      check({tag, ".etype"}, 64'(etype_o), 64'(m_etype));
      check({tag, ".eid"},   64'(eid_o),   64'(m_eid));
      check({tag, ".addr"},  addr_o,       m_addr);
      check({tag, ".sid"},   64'(sid_o),   64'(m_sid));
      check({tag, ".drop"},  64'(drop_o),  FEAT ? 64'(m_drop) : 64'd0);
   endtask

   // Drives one cycle of inputs, lets the edge pass, and advances the model.
   task automatic apply(input logic vl, input logic er, input logic [2:0] et,
                        input logic [2:0] ac, input logic [15:0] ei,
                        input logic [63:0] ad, input logic [7:0] si,
                        input logic ien, input logic cl);
      valid = vl; err = er; etype = et; acc = ac; eid = ei; addr = ad;
      sid = si; ie = ien; clr = cl;
      @(posedge clk);
      #1;
      model_step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      valid = 1'b0; err = 1'b0; clr = 1'b0; ie = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      //          vl  er  et    ac    eid     addr              sid  ie  clr | v irq ev etype eid    addr              drop
      vt[0] = mk(1'b1,1'b1,3'd2,3'd2,16'd5, 64'h8000_1000, 8'd3,1'b1,1'b0, 1'b1,1'b1,1'b1,3'd2,16'd5,64'h8000_1000,0);
      vt[1] = mk(1'b0,1'b0,3'd0,3'd0,16'd0, 64'h0,         8'd0,1'b1,1'b0, 1'b1,1'b1,1'b0,3'd2,16'd5,64'h8000_1000,0);
      vt[2] = mk(1'b1,1'b1,3'd5,3'd1,16'd0, 64'h40,        8'd9,1'b1,1'b0, 1'b1,1'b1,1'b1,3'd2,16'd5,64'h8000_1000,1);
      vt[3] = mk(1'b1,1'b1,3'd3,3'd4,16'd7, 64'h200,       8'd1,1'b1,1'b1, 1'b1,1'b1,1'b1,3'd3,16'd7,64'h200,       0);
      vt[4] = mk(1'b0,1'b0,3'd0,3'd0,16'd0, 64'h0,         8'd0,1'b0,1'b1, 1'b0,1'b0,1'b0,3'd3,16'd7,64'h200,       0);
      vt[5] = mk(1'b1,1'b0,3'd1,3'd1,16'd2, 64'h77,        8'd2,1'b0,1'b0, 1'b0,1'b0,1'b0,3'd3,16'd7,64'h200,       0);
      vt[6] = mk(1'b0,1'b0,3'd0,3'd0,16'd0, 64'h0,         8'd0,1'b1,1'b1, 1'b0,1'b0,1'b0,3'd3,16'd7,64'h200,       0);
      vt[7] = mk(1'b1,1'b1,3'd1,3'd1,16'd9, 64'h1234,      8'd4,1'b1,1'b0, 1'b1,1'b1,1'b1,3'd1,16'd9,64'h1234,      0);
      vt[8] = mk(1'b0,1'b0,3'd0,3'd0,16'd0, 64'h0,         8'd0,1'b0,1'b0, 1'b1,1'b0,1'b0,3'd1,16'd9,64'h1234,      0);

      // Reset state while reset is held
      do_reset();
      rst = 1'b1;
      #1;
      check("rst.v", 64'(v_o), 64'd0);
      check("rst.irq", 64'(irq_o), 64'd0);
      check("rst.event", 64'(ev_o), 64'd0);
      check("rst.addr", addr_o, 64'd0);
      check("rst.drop", 64'(drop_o), 64'd0);
      do_reset();

      // Passing traffic never changes state
      for (int i = 0; i < 10; i++) begin
         apply(1'b1, 1'b0, 3'd2, 3'd1, 16'(i), 64'(i * 64'h100), 8'(i), 1'b1, 1'b0);
         check("idle.v", 64'(v_o), 64'd0);
         check("idle.irq", 64'(irq_o), 64'd0);
         check("idle.event", 64'(ev_o), 64'd0);
      end

      // Directed vector table
      for (int i = 0; i < 9; i++) begin
         apply(vt[i].valid, vt[i].err, vt[i].etype, vt[i].acc, vt[i].eid,
               vt[i].addr, vt[i].sid, vt[i].ie, vt[i].clr);
         check($sformatf("vec%0d.v", i),     64'(v_o),     64'(vt[i].x_v));
         check($sformatf("vec%0d.irq", i),   64'(irq_o),   64'(vt[i].x_irq));
         check($sformatf("vec%0d.event", i), 64'(ev_o),    64'(vt[i].x_ev));
         check($sformatf("vec%0d.etype", i), 64'(etype_o), 64'(vt[i].x_etype));
         check($sformatf("vec%0d.eid", i),   64'(eid_o),   64'(vt[i].x_eid));
         check($sformatf("vec%0d.addr", i),  addr_o,       vt[i].x_addr);
         check($sformatf("vec%0d.drop", i),  64'(drop_o),  FEAT ? 64'(vt[i].x_drop_feat) : 64'd0);
      end
      check("vec0.sid_final", 64'(sid_o), 64'd4);
      check("vec0.ttype_final", 64'(ttype_o), 64'd1);

      // Clear in IDLE has no effect; then 5 drops saturate the 2-bit counter
      do_reset();
      apply(1'b0, 1'b0, 3'd0, 3'd0, 16'd0, 64'd0, 8'd0, 1'b1, 1'b1);
      check("idleclr.v", 64'(v_o), 64'd0);
      apply(1'b1, 1'b1, 3'd7, 3'd3, 16'd11, 64'hABCD, 8'd6, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         apply(1'b1, 1'b1, 3'd1, 3'd1, 16'(20 + i), 64'(i), 8'd0, 1'b1, 1'b0);
         check_model("sat");
      end
      check("sat.final", 64'(drop_o), FEAT ? 64'd3 : 64'd0);
      check("sat.eid_kept", 64'(eid_o), 64'd11);

      // Reset mid-LOCKED clears outputs immediately, without a clock edge
      rst = 1'b1;
      #1;
      check("midrst.v", 64'(v_o), 64'd0);
      check("midrst.irq", 64'(irq_o), 64'd0);
      check("midrst.eid", 64'(eid_o), 64'd0);
      check("midrst.addr", addr_o, 64'd0);
      check("midrst.drop", 64'(drop_o), 64'd0);
      check("midrst.event", 64'(ev_o), 64'd0);
      do_reset();

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         logic [2:0] et;
         case ($urandom_range(4, 0))
            0: et = 3'd1;
            1: et = 3'd2;
            2: et = 3'd3;
            3: et = 3'd5;
            default: et = 3'd7;
         endcase
         apply(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), et,
               3'($urandom), 16'($urandom), {$urandom, $urandom}, 8'($urandom),
               1'($urandom_range(1, 0)), ($urandom_range(3, 0) == 0));
         check_model($sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rv_iopmp_err_capture.md
Name: rv_iopmp_err_capture

Overview:
Sequential error-record stage directly downstream of the IOPMP decision logic. Samples each checked transaction's error verdict and latches the first failing transaction's type, error code, entry index, address and SID into a locked record. The record feeds the ERR_REQINFO/ERR_REQADDR/ERR_REQID register view. Raises an interrupt and holds until software clears it. Further errors while locked are dropped, not overwritten.

Parameters:
ADDR_WIDTH, 64, width of captured transaction address
SID_WIDTH, 8, width of captured source ID
CNT_WIDTH, 16, width of dropped-error counter (optional feature only)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
txn_valid_i  in  1  decision-logic verdict valid this cycle (one transaction per cycle max)
err_transaction_i  in  1  verdict is an error
err_type_i  in  3  error code: 1 read, 2 write, 3 exec, 5 no-hit, 7 other
err_entry_index_i  in  16  failing entry index (0 for no-hit)
txn_access_i  in  3  access type of the transaction (rv_iopmp_pkg::access_t)
txn_addr_i  in  ADDR_WIDTH  transaction address
txn_sid_i  in  SID_WIDTH  transaction source ID
intr_en_i  in  1  global interrupt enable (ERR_CFG.ie)
clear_i  in  1  software write-1 to ERR_REQINFO.v; single-cycle pulse
err_v_o  out  1  record valid/locked
err_ttype_o  out  3  captured access type
err_etype_o  out  3  captured error code
err_eid_o  out  16  captured entry index
err_addr_o  out  ADDR_WIDTH  captured address
err_sid_o  out  SID_WIDTH  captured SID
irq_o  out  1  level interrupt
err_event_o  out  1  one-cycle pulse on each error verdict, captured or dropped
drop_cnt_o  out  CNT_WIDTH  dropped-error count (optional feature)

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; record fields 0.
- Error event: txn_valid_i & err_transaction_i. Inputs with txn_valid_i=0 are ignored entirely.
- States: IDLE (no record), LOCKED (record held).
- IDLE + error event -> capture all fields on the clock edge -> LOCKED. err_v_o=1 in the following cycle (1-cycle latency).
- IDLE + clear_i -> no effect.
- LOCKED + error event, no clear -> record unchanged; event dropped.
- LOCKED + clear_i, no event -> IDLE next cycle; err_v_o=0. Record fields keep their stale value (software qualifies with err_v_o).
- LOCKED + clear_i + error event in the same cycle -> new event captured; remains LOCKED; err_v_o stays 1; not counted as dropped.
- irq_o = err_v_o & intr_en_i, combinational from registered err_v_o. Toggling intr_en_i masks/unmasks without touching the record.
- err_event_o registered: high one cycle after every error event, regardless of state.
- Successful transactions (err_transaction_i=0) never modify state.
- Reset asserted mid-LOCKED: immediate return to IDLE, all outputs 0.

Optional Feature:
RV_IOPMP_ERR_DROP_CNT_EN
- Defined: drop_cnt_o increments by 1 on each dropped error event (LOCKED, no same-cycle clear). Saturates at 2^CNT_WIDTH-1. Zeroed on reset and on any cycle where clear_i is accepted in LOCKED. Clear wins over increment.
- Undefined: port present, tied to 0; no counter flops.

Test Plan:
- Reset then idle traffic with txn_valid_i=1, err_transaction_i=0 for 10 cycles -> err_v_o=0, irq_o=0, err_event_o=0 throughout.
- IDLE error: etype=2, eid=5, addr=0x8000_1000, sid=3, access=WRITE, intr_en_i=1 -> next cycle err_v_o=1, fields match, irq_o=1, err_event_o pulses once.
- While LOCKED, inject etype=5 addr=0x40 -> record still holds eid=5/addr=0x8000_1000; err_event_o pulses; drop_cnt_o=1 if feature defined, else 0.
- clear_i and error (etype=3, eid=7, addr=0x200) in the same cycle while LOCKED -> err_v_o stays 1, eid=7, addr=0x200; drop_cnt_o=0.
- clear_i alone while LOCKED with intr_en_i=0 -> err_v_o=0 next cycle, irq_o=0; a later error recaptures.
- Feature defined, CNT_WIDTH=2: 5 dropped errors -> drop_cnt_o saturates at 3. Assert rst_i mid-LOCKED -> outputs 0 immediately.
